sensor_acquire: RTL

Front end of the height-measurement path. It polls the four baggage-drop height sensors one at a time over a shared request/acknowledge bus and captures each 8-bit reading. It then presents all four readings atomically, with a one-cycle valid pulse, to the height-averaging logic. A sensor that does not answer within a bounded time is reported as 0, which the averaging logic treats as a failed sensor.

---
 rtl/sensor_acquire.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sensor_acquire.sv
// Polls four height sensors in turn over a shared req/ack bus and publishes
// all four readings together with a one-cycle valid pulse; silent sensors read as 0.
module sensor_acquire #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sensor_req,
  output logic [1:0] sensor_sel,
  input  logic       sensor_ack,
  input  logic [7:0] sensor_data,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic [3:0] timeout_err,
  output logic       valid,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_sh0, r_sh1, r_sh2;
  logic [2:0]        r_err;
  logic [DATA_W-1:0] r_s1, r_s2, r_s3, r_s4;
  logic [3:0]        r_terr;
  logic              r_valid;

  logic              w_launch, w_ack, w_tmo, w_done, w_commit;
  logic [DATA_W-1:0] w_val;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Ack has priority over timeout when both land in the same REQ cycle.
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_ack    = 1'b0;
    w_tmo    = 1'b0;
    w_done   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_launch = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        w_ack  = sensor_ack;
        w_tmo  = !sensor_ack && (r_cnt == CNT_LAST);
        w_done = w_ack || w_tmo;
        if (w_done) begin
          if (r_sel == 2'd3) begin
            w_next   = IDLE;
            w_commit = 1'b1;
          end else begin
            w_next = GAP;
          end
        end
      end
      GAP:     w_next = REQ;
      default: w_next = IDLE;
    endcase
  end

  assign w_val = w_ack ? sensor_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_err   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_s4    <= '0;
      r_terr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (r_state == REQ && !w_done) r_cnt <= r_cnt + 1'b1;
      else                           r_cnt <= '0;

      if (w_launch) begin
        r_sel <= '0;
        r_sh0 <= '0;
        r_sh1 <= '0;
        r_sh2 <= '0;
        r_err <= '0;
      end else if (r_state == GAP) begin
        r_sel <= r_sel + 2'd1;
      end

      if (w_done) begin
        case (r_sel)
          2'd0: begin r_sh0 <= w_val; r_err[0] <= w_tmo; end
          2'd1: begin r_sh1 <= w_val; r_err[1] <= w_tmo; end
          2'd2: begin r_sh2 <= w_val; r_err[2] <= w_tmo; end
          default: ;
        endcase
      end

      // The last sensor's result bypasses the shadow so the commit is atomic.
      if (w_commit) begin
        r_s1   <= r_sh0;
        r_s2   <= r_sh1;
        r_s3   <= r_sh2;
        r_s4   <= w_val;
        r_terr <= {w_tmo, r_err};
      end
    end
  end

  assign sensor_req  = (r_state == REQ);
  assign busy        = (r_state != IDLE);
  assign sensor_sel  = r_sel;
  assign sensor1     = r_s1;
  assign sensor2     = r_s2;
  assign sensor3     = r_s3;
  assign sensor4     = r_s4;
  assign timeout_err = r_terr;
  assign valid       = r_valid;

endmodule
